mux_burst_sequencer: RTL and testbench
======================================

Name: mux_burst_sequencer

Overview:
- Command-driven controller that sits directly upstream of, and around, the asynchronous 3-input 8-bit select mux.
- Accepts a burst command (channel select, length) over a valid/ready handshake.
- Drives the mux chip-select and select lines from registers for the burst length, and samples the mux output every burst cycle.
- Returns a modular sum plus the last sample over a second valid/ready handshake to the downstream consumer.

Parameters:
- LEN_W, 8, width of burst length field; max burst 2^LEN_W-1 cycles.
- ACC_W, 12, width of sum accumulator; sum wraps modulo 2^ACC_W.

Ports:
- clk  in  1  single clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_sel  in  2  mux select for the burst.
- cmd_len  in  LEN_W  burst length in cycles.
- mux_cs  out  1  registered chip select to the mux.
- mux_sel  out  2  registered select to the mux.
- mux_data  in  8  combinational mux output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_sum  out  ACC_W  sum of sampled mux_data, wrapped.
- res_last  out  8  final sample of the burst (0 if len=0).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, nReset=0): state=IDLE; mux_cs=0, mux_sel=0, res_valid=0, res_sum=0, res_last=0, busy=0, internal counter=0. Reset mid-burst aborts immediately; no result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, mux_cs=0.
  - On cmd_valid&cmd_ready at edge t: latch cmd_sel into mux_sel, clear sum.
  - If cmd_len=0: go to DONE, with res_sum=0 and res_last=0.
  - Otherwise: cnt=cmd_len, mux_cs=1, go to RUN.
- RUN:
  - cmd_ready=0; mux_cs=1; mux_sel stable.
  - Each cycle: sum <= sum + zero-extended mux_data (mod 2^ACC_W); res_last <= mux_data; cnt <= cnt-1.
  - When cnt=1: take the final sample, clear mux_cs, go to DONE.
- DONE:
  - res_valid=1; res_sum and res_last held stable while res_ready=0.
  - On res_ready=1: res_valid <= 0, go to IDLE.
  - No command is accepted in DONE; cmd_ready=0 because there is no skid.
- Latency: command accepted at edge t. mux_cs high during cycles t+1..t+len. res_valid high from edge t+len+1. len=0 gives res_valid at t+1.
- Throughput: after a result is taken, the earliest next accept is one cycle later, since cmd_ready rises in IDLE.
- mux_sel is held after a burst until the next accept. mux_cs is never high outside RUN.
- sel=2'b11 is legal. The mux outputs 0, so the burst yields sum 0 and last 0.
- Mux is combinational: mux_data is sampled in the same cycle that mux_cs/mux_sel are presented.

Optional Feature:
- Macro MUX_BURST_PARITY_EN.
- Defined: extra output res_parity (1 bit) = XOR-reduction of all bits of every sample in the burst. Resets to 0, clears on accept, valid with res_valid. len=0 gives 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mux_burst_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - constants DATA_W=8, SEL_W=2;
  - localparam SEL_NONE=2'b11.
- One natural sub-module: mux_burst_acc. It holds the accumulator, last-sample register and optional parity, with inputs clear/en/data.
- The FSM and counter stay in the top level.

Test Plan:
- Basic alpha burst: alpha=8'h05, cmd_sel=0, len=3 -> mux_cs high exactly 3 cycles; res_valid at t+4; res_sum=15, res_last=5.
- Invalid select: cmd_sel=3, len=4, alpha/beta/gamma=8'hAA -> res_sum=0, res_last=0, mux_cs high 4 cycles.
- Accumulator wrap: cmd_sel=2, gamma=8'hFF, len=20, ACC_W=12 -> 5100 mod 4096, so res_sum=12'h3EC, res_last=8'hFF.
- Zero length: len=0 -> res_valid one cycle after accept; sum=0; mux_cs never asserted.
- Backpressure: res_ready low 5 cycles after res_valid -> res_sum/res_last stable, cmd_ready=0, and a cmd_valid pulse is ignored. Raising res_ready returns the block to IDLE next cycle.
- Async reset: nReset pulsed low mid-RUN (cnt=2) -> mux_cs=0 and busy=0 immediately without a clock edge; no res_valid afterwards; next command runs normally.

Source files
------------

// File: rtl/mux_burst_pkg.sv
// Shared types and constants for the mux burst sequencer.
// Optional parity output is enabled with the MUX_BURST_PARITY_EN macro.
package mux_burst_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  // Select code that routes no input; the mux drives zero for it.
  localparam logic [SEL_W-1:0] SEL_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic sample_parity(input logic [DATA_W-1:0] sample);
    return ^sample;
  endfunction

endpackage

// File: rtl/mux_burst_acc.sv
// Burst accumulator: wrapping sum, last sample and (MUX_BURST_PARITY_EN) running parity.
// clear has priority over en; both act on the rising edge.
module mux_burst_acc
  import mux_burst_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
`ifdef MUX_BURST_PARITY_EN
  output logic              parity,
`endif
  output logic [ACC_W-1:0]  sum,
  output logic [DATA_W-1:0] last
);

  logic [ACC_W-1:0]  sum_q,  sum_d;
  logic [DATA_W-1:0] last_q, last_d;

  // Next-value logic for the sum and last-sample registers.
  always_comb begin
    sum_d  = sum_q;
    last_d = last_q;
    if (clear) begin
      sum_d  = {ACC_W{1'b0}};
      last_d = {DATA_W{1'b0}};
    end else if (en) begin
      sum_d  = sum_q + ACC_W'(data);
      last_d = data;
    end else begin
      sum_d  = sum_q;
      last_d = last_q;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sum_q  <= {ACC_W{1'b0}};
      last_q <= {DATA_W{1'b0}};
    end else begin
      sum_q  <= sum_d;
      last_q <= last_d;
    end
  end

  assign sum  = sum_q;
  assign last = last_q;

`ifdef MUX_BURST_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (clear) begin
      parity_d = 1'b0;
    end else if (en) begin
      parity_d = parity_q ^ sample_parity(data);
    end else begin
      parity_d = parity_q;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: rtl/mux_burst_sequencer.sv
// Command-driven burst controller around a combinational 3-input select mux.
// Define MUX_BURST_PARITY_EN to add the res_parity output.
module mux_burst_sequencer
  import mux_burst_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 12
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mux_cs,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_sum,
  output logic [DATA_W-1:0] res_last,
`ifdef MUX_BURST_PARITY_EN
  output logic              res_parity,
`endif
  output logic              busy
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              cs_q, cs_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              rv_q, rv_d;
  logic              acc_clear_s;
  logic              acc_en_s;

  // Next-state, counter and mux-control decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    sel_d       = sel_q;
    rv_d        = rv_q;
    acc_clear_s = 1'b0;
    acc_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          sel_d       = cmd_sel;
          acc_clear_s = 1'b1;
          if (cmd_len == {LEN_W{1'b0}}) begin
            cs_d    = 1'b0;
            rv_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = cmd_len;
            cs_d    = 1'b1;
            state_d = ST_RUN;
          end
        end else begin
          cs_d = 1'b0;
        end
      end
      ST_RUN: begin
        acc_en_s = 1'b1;
        cnt_d    = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          cs_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          cs_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          rv_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {LEN_W{1'b0}};
        cs_d    = 1'b0;
        rv_d    = 1'b0;
      end
    endcase
  end

  // Reset aborts any burst at once and drops the chip select.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {LEN_W{1'b0}};
      cs_q    <= 1'b0;
      sel_q   <= {SEL_W{1'b0}};
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      sel_q   <= sel_d;
      rv_q    <= rv_d;
    end
  end

  mux_burst_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .nReset (nReset),
    .clear  (acc_clear_s),
    .en     (acc_en_s),
    .data   (mux_data),
`ifdef MUX_BURST_PARITY_EN
    .parity (res_parity),
`endif
    .sum    (res_sum),
    .last   (res_last)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign mux_cs    = cs_q;
  assign mux_sel   = sel_q;
  assign res_valid = rv_q;

endmodule

// File: tb/tb_mux_burst_sequencer.sv
// Randomized self-checking bench for mux_burst_sequencer with a behavioural mux and burst model.
module tb_mux_burst_sequencer;
  import mux_burst_pkg::*;

  localparam int LEN_W = 8;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             nReset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_sel;
  logic [LEN_W-1:0] cmd_len;
  logic             mux_cs;
  logic [1:0]       mux_sel;
  logic [7:0]       mux_data;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_sum;
  logic [7:0]       res_last;
  logic             busy;
`ifdef MUX_BURST_PARITY_EN
  logic             res_parity;
`endif

  // Per-channel value presented in the k-th cycle after the accept edge.
  logic [7:0] src [0:2][0:255];
  int         k;
  int         n_checks;
  int         n_errors;

  always #5 clk = ~clk;

  // Behavioural model of the external mux: zero when deselected or for the unused select.
  always_comb begin
    mux_data = 8'h00;
    if (mux_cs && (mux_sel != SEL_NONE)) begin
      mux_data = src[mux_sel][k[7:0]];
    end
  end

  mux_burst_sequencer #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .mux_cs    (mux_cs),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_last  (res_last),
`ifdef MUX_BURST_PARITY_EN
    .res_parity(res_parity),
`endif
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int ch, input bit rnd, input logic [7:0] v);
    for (int i = 0; i < 256; i++) begin
      src[ch][i] = rnd ? 8'($urandom) : v;
    end
  endtask

  // One full burst: accept, run, optional backpressure, then hand the result off.
  task automatic run_burst(input logic [1:0] sel, input int len, input int hold);
    int         exp_sum = 0;
    logic [7:0] exp_last = 8'h00;
    int         lat = 0;
    int         cs_cnt = 0;
    bit         sel_ok = 1'b1;
`ifdef MUX_BURST_PARITY_EN
    logic       exp_par = 1'b0;
`endif
    for (int i = 1; i <= len; i++) begin
      if (sel != SEL_NONE) begin
        exp_sum  = exp_sum + int'(src[sel][i]);
        exp_last = src[sel][i];
`ifdef MUX_BURST_PARITY_EN
        exp_par  = exp_par ^ (^src[sel][i]);
`endif
      end
    end
    exp_sum = exp_sum % (1 << ACC_W);

    @(negedge clk);
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_len   = len[LEN_W-1:0];
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_sel   = 2'($urandom);
    cmd_len   = 8'($urandom);
    k = 1;
    while (1) begin
      @(negedge clk);
      lat++;
      if (res_valid) break;
      if (mux_cs) begin
        cs_cnt++;
        if (mux_sel !== sel) sel_ok = 1'b0;
      end
      if (lat > len + 8) break;
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("latency", lat, len + 1);
    check_eq("mux_cs_cycles", cs_cnt, len);
    check_eq("mux_sel_stable", 32'(sel_ok), 1);
    check_eq("res_sum", res_sum, exp_sum);
    check_eq("res_last", res_last, exp_last);
`ifdef MUX_BURST_PARITY_EN
    check_eq("res_parity", res_parity, exp_par);
`endif
    check_eq("done_cs_low", mux_cs, 0);
    check_eq("done_busy", busy, 1);
    check_eq("done_cmd_ready", cmd_ready, 0);

    for (int h = 0; h < hold; h++) begin
      cmd_valid = (h == hold / 2);
      cmd_len   = 8'd3;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("hold_valid", res_valid, 1);
      check_eq("hold_sum", res_sum, exp_sum);
      check_eq("hold_last", res_last, exp_last);
      check_eq("hold_cmd_ready", cmd_ready, 0);
      check_eq("hold_cs", mux_cs, 0);
    end

    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    check_eq("taken_valid", res_valid, 0);
    check_eq("taken_cmd_ready", cmd_ready, 1);
    check_eq("taken_busy", busy, 0);
    check_eq("taken_cs", mux_cs, 0);
    check_eq("sel_held", mux_sel, sel);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  len;
    bit  saw_valid;
    n_checks  = 0;
    n_errors  = 0;
    nReset    = 1'b0;
    cmd_valid = 1'b0;
    cmd_sel   = 2'd0;
    cmd_len   = 8'd0;
    res_ready = 1'b0;
    k         = 0;
    for (int c = 0; c < 3; c++) fill(c, 1'b1, 8'h00);

    #2;
    check_eq("rst_cs", mux_cs, 0);
    check_eq("rst_sel", mux_sel, 0);
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_sum", res_sum, 0);
    check_eq("rst_last", res_last, 0);
    check_eq("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    nReset = 1'b1;

    // Directed scenarios.
    fill(0, 1'b0, 8'h05);
    run_burst(2'd0, 3, 0);
    for (int c = 0; c < 3; c++) fill(c, 1'b0, 8'hAA);
    run_burst(2'd3, 4, 0);
    fill(2, 1'b0, 8'hFF);
    run_burst(2'd2, 20, 0);
    check_eq("wrap_sum_const", res_sum, 12'h3EC);
    fill(1, 1'b1, 8'h00);
    run_burst(2'd1, 0, 0);
    fill(0, 1'b1, 8'h00);
    run_burst(2'd0, 2, 5);

    // Asynchronous reset in RUN with two samples outstanding.
    fill(0, 1'b1, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_sel   = 2'd0;
    cmd_len   = 8'd5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    k = 1;
    repeat (3) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq("pre_rst_cs", mux_cs, 1);
    #1;
    nReset = 1'b0;
    #1;
    check_eq("arst_cs", mux_cs, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_valid", res_valid, 0);
    @(negedge clk);
    nReset = 1'b1;
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) saw_valid = 1'b1;
    end
    check_eq("arst_no_result", 32'(saw_valid), 0);
    fill(1, 1'b1, 8'h00);
    run_burst(2'd1, 6, 1);

    // Randomized bursts.
    for (int n = 0; n < 25; n++) begin
      for (int c = 0; c < 3; c++) fill(c, 1'b1, 8'h00);
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(40, 255)) : int'($urandom_range(0, 12));
      run_burst(2'($urandom_range(0, 3)), len, int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
